scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, at least 2).
REQ-003 SHALL have derived localparam AW = $clog2(NREG), meaning address width.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset: rst=0 resets immediately; release is synchronous to clk.
REQ-006 rs1_addr, rs2_addr  input  AW  read port addresses.
REQ-007 rs1_data, rs2_data  output  XLEN  combinational read data.
REQ-008 rs1_busy, rs2_busy  output  1  read register has a pending (reserved, unwritten) result.
REQ-009 wr_en  input  1, wr_addr  input  AW, wr_data  input  XLEN  writeback port.
REQ-010 rsv_valid  input  1, rsv_addr  input  AW  destination reservation request from issue.
REQ-011 rsv_ready  output  1  reservation accepted this cycle.
REQ-012 pend_cnt  output  $clog2(NREG+1)  number of busy registers.

Function
REQ-013 SHALL hardwire register 0: reads return 0; rs*_busy is 0; writes to it are discarded; reservations of it are accepted without setting busy.
REQ-014 SHALL write wr_data into register wr_addr on the clock edge when wr_en=1 and wr_addr!=0.
REQ-015 SHALL clear busy[wr_addr] on the clock edge when wr_en=1.
REQ-016 rsv_ready SHALL equal rsv_valid and (rsv_addr==0 or busy[rsv_addr]==0 or (wr_en and wr_addr==rsv_addr)); this enforces a WAW stall.
REQ-017 SHALL set busy[rsv_addr] on the clock edge when rsv_valid and rsv_ready and rsv_addr!=0.
REQ-018 Same-cycle writeback and reservation to the same nonzero address SHALL leave busy=1, with the data written.
REQ-019 SHALL update pend_cnt in the same edge as busy: +1 for a set, -1 for a clear, 0 net for REQ-018; pend_cnt never exceeds NREG-1.
REQ-020 A write to a non-busy register SHALL be legal: the data is written and busy stays 0.
REQ-021 Read outputs SHALL be purely combinational with zero latency.

Reset
REQ-022 rst=0 SHALL clear all registers to 0, all busy bits to 0, and pend_cnt to 0.
REQ-023 While rst=0: rs*_data=0, rs*_busy=0, rsv_ready=0, and writes are ignored.
REQ-024 Reset asserted mid-operation SHALL discard all pending reservations; there are no initial-block register presets.

Configuration
REQ-025 With macro SCOREBOARD_REGFILE_BYPASS_EN defined: when wr_en=1 and wr_addr==rsN_addr!=0, rsN_data SHALL be wr_data and rsN_busy SHALL be 0 (write-through forwarding), unless REQ-018 applies, in which case busy reads 0 this cycle only.
REQ-026 Without the macro: the read SHALL return the stored pre-edge value and the current busy bit; the new value is visible from the next cycle.

Structure
REQ-027 A shared package regfile_pkg SHALL hold the default XLEN/NREG constants and a typedef for the busy vector.
REQ-028 One sub-module, sb_popcount, is natural for pend_cnt (NREG-bit population count) and is used for assertion cross-checks; the running counter is the primary implementation.

Verification
REQ-029 Reset then read: rst=0 then 1, read x9 -> 0, busy 0, pend_cnt 0.
REQ-030 Reserve x5, then a second reserve of x5 -> first rsv_ready=1, pend_cnt=1; second rsv_ready=0 (WAW stall) until writeback.
REQ-031 Writeback x5=32'hDEADBEEF while rs1_addr=5 -> with BYPASS_EN, rs1_data=DEADBEEF and busy=0 the same cycle; without it, old value and busy=1, then DEADBEEF next cycle; pend_cnt=0.
REQ-032 Same-cycle write x7=32'h1234 and reserve x7 -> next cycle x7=1234, busy=1, pend_cnt unchanged.
REQ-033 Write x0=32'hFFFFFFFF and reserve x0 -> x0 reads 0, rsv_ready=1, busy 0, pend_cnt 0.
REQ-034 Reserve x1..x31 (pend_cnt=31), assert rst=0 mid-sequence -> all busy 0, pend_cnt 0, all reads 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   typedef logic [NREG_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/sb_popcount.sv
// Population count of an N-bit vector, used to cross-check the pending counter.
module sb_popcount #(
   parameter  int N = 32,
   localparam int W = $clog2(N + 1)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + W'(vec[i]);
      end
   end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy scoreboard and WAW reservation stall.
// Optional write-through forwarding on the read ports: SCOREBOARD_REGFILE_BYPASS_EN.
module scoreboard_regfile
   import regfile_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   parameter  int NREG = NREG_DEF,
   localparam int AW   = $clog2(NREG),
   localparam int CW   = $clog2(NREG + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            rsv_valid,
   input  logic [AW-1:0]   rsv_addr,
   output logic            rsv_ready,
   output logic [CW-1:0]   pend_cnt
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic            wr_hit;
   logic            rsv_set;
   logic            cnt_inc;
   logic            cnt_dec;
   logic [CW-1:0]   pop_cnt;

   assign wr_hit = wr_en && (wr_addr != '0);

   // A busy destination may still be re-reserved when its writeback lands this cycle.
   always_comb begin
      rsv_ready = rst && rsv_valid &&
                  ((rsv_addr == '0) || !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
   end

   assign rsv_set = rsv_ready && (rsv_addr != '0);
   assign cnt_inc = rsv_set && !busy[rsv_addr];
   assign cnt_dec = wr_en && busy[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Reservation wins over writeback so a same-cycle write+reserve leaves the entry busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int i = 1; i < NREG; i++) begin
            if (rsv_set && (rsv_addr == AW'(i))) begin
               busy[i] <= 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
               busy[i] <= 1'b0;
            end
         end
         if (cnt_inc && !cnt_dec) begin
            pend_cnt <= pend_cnt + 1'b1;
         end else if (cnt_dec && !cnt_inc) begin
            pend_cnt <= pend_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      rs1_data = regs[rs1_addr];
      rs1_busy = busy[rs1_addr];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rs1_addr)) begin
         rs1_data = wr_data;
         rs1_busy = 1'b0;
      end
`endif
      if (!rst || (rs1_addr == '0)) begin
         rs1_data = '0;
         rs1_busy = 1'b0;
      end
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      rs2_busy = busy[rs2_addr];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rs2_addr)) begin
         rs2_data = wr_data;
         rs2_busy = 1'b0;
      end
`endif
      if (!rst || (rs2_addr == '0)) begin
         rs2_data = '0;
         rs2_busy = 1'b0;
      end
   end

   sb_popcount #(
      .N (NREG)
   ) u_popcount (
      .vec (busy),
      .cnt (pop_cnt)
   );

   a_pend_matches_busy: assert property (@(posedge clk) disable iff (!rst) pend_cnt == pop_cnt);
   a_pend_bounded:      assert property (@(posedge clk) disable iff (!rst) pend_cnt <= CW'(NREG - 1));

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed plus randomized bench for scoreboard_regfile against an array-based model.
module tb_scoreboard_regfile;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int CW   = 6;

   logic            clk;
   logic            rst;
   logic [AW-1:0]   rs1_addr, rs2_addr;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            rsv_valid;
   logic [AW-1:0]   rsv_addr;
   logic            rsv_ready;
   logic [CW-1:0]   pend_cnt;

   int checks   = 0;
   int failures = 0;

   logic [XLEN-1:0] m_regs [NREG];
   bit              m_busy [NREG];

   logic [XLEN-1:0] last_rs1_data;
   logic            last_rs1_busy;
   logic            last_ready;

   scoreboard_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .pend_cnt  (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_pend();
      int n = 0;
      for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
      if (!rst || a == 0) return 32'h0;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) return wr_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (!rst || a == 0) return 1'b0;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   function automatic logic exp_ready();
      return rst && rsv_valid &&
             (rsv_addr == 0 || !m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Model state change for one rising edge, using the pre-edge busy bits.
   task automatic m_edge();
      logic ok;
      if (!rst) return;
      ok = exp_ready();
      if (wr_en) begin
         m_busy[wr_addr] = 1'b0;
         if (wr_addr != 0) m_regs[wr_addr] = wr_data;
      end
      if (ok && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
   endtask

   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2, input string tag);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_valid = rv; rsv_addr = ra;
      rs1_addr = r1; rs2_addr = r2;
      #1;
      last_rs1_data = rs1_data;
      last_rs1_busy = rs1_busy;
      last_ready    = rsv_ready;
      check({tag, ".rs1_data"}, rs1_data, exp_data(r1));
      check({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(r1)));
      check({tag, ".rs2_data"}, rs2_data, exp_data(r2));
      check({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(r2)));
      check({tag, ".rsv_ready"}, 32'(rsv_ready), 32'(exp_ready()));
      check({tag, ".pend_pre"}, 32'(pend_cnt), 32'(m_pend()));
      @(posedge clk);
      m_edge();
      #1;
      check({tag, ".pend_post"}, 32'(pend_cnt), 32'(m_pend()));
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_valid = 1'b0; rsv_addr = '0;
   endtask

   initial begin
      logic [AW-1:0]   wa, ra, r1, r2;
      logic [XLEN-1:0] wd;
      logic            we, rv;

      m_reset();
      idle_inputs();
      rs1_addr = '0; rs2_addr = '0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // In reset: reservations refused, writes ignored, reads zero.
      step(1'b1, 5'd3, 32'hAAAA_5555, 1'b1, 5'd3, 5'd3, 5'd9, "inrst");
      check("inrst.ready0", 32'(last_ready), 32'd0);
      step(1'b1, 5'd9, 32'h1111_2222, 1'b1, 5'd0, 5'd9, 5'd3, "inrst2");
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;

      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3, "rd9");
      check("rd9.data", last_rs1_data, 32'h0);
      check("rd9.pend", 32'(pend_cnt), 32'd0);

      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, "rsv5a");
      check("rsv5a.ready", 32'(last_ready), 32'd1);
      check("rsv5a.pend", 32'(pend_cnt), 32'd1);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, "rsv5b");
      check("rsv5b.waw_stall", 32'(last_ready), 32'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, "rsv5c");
      check("rsv5c.waw_stall", 32'(last_ready), 32'd0);

      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5, "wb5");
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      check("wb5.fwd_data", last_rs1_data, 32'hDEAD_BEEF);
      check("wb5.fwd_busy", 32'(last_rs1_busy), 32'd0);
`else
      check("wb5.old_data", last_rs1_data, 32'h0);
      check("wb5.old_busy", 32'(last_rs1_busy), 32'd1);
`endif
      check("wb5.pend", 32'(pend_cnt), 32'd0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, "rd5");
      check("rd5.data", last_rs1_data, 32'hDEAD_BEEF);
      check("rd5.busy", 32'(last_rs1_busy), 32'd0);

      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5, "rsv7");
      step(1'b1, 5'd7, 32'h0000_1234, 1'b1, 5'd7, 5'd7, 5'd5, "wbrsv7");
      check("wbrsv7.ready", 32'(last_ready), 32'd1);
      check("wbrsv7.pend", 32'(pend_cnt), 32'd1);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, "rd7");
      check("rd7.data", last_rs1_data, 32'h0000_1234);
      check("rd7.busy", 32'(last_rs1_busy), 32'd1);
      step(1'b1, 5'd7, 32'h0000_1234, 1'b0, 5'd0, 5'd7, 5'd0, "wb7");

      step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd7, "x0");
      check("x0.ready", 32'(last_ready), 32'd1);
      check("x0.data", last_rs1_data, 32'h0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, "rd0");
      check("rd0.data", last_rs1_data, 32'h0);
      check("rd0.busy", 32'(last_rs1_busy), 32'd0);
      check("rd0.pend", 32'(pend_cnt), 32'd0);

      // Fill x1..x20 with reservations, then drop reset asynchronously mid-cycle.
      for (int a = 1; a <= 20; a++) begin
         step(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(a), 5'd5, "fill");
      end
      check("fill.pend20", 32'(pend_cnt), 32'd20);
      #2 rst = 1'b0;
      m_reset();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
      for (int a = 0; a < NREG; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(NREG - 1 - a);
         #1;
         check("arst.rs1_data", rs1_data, 32'h0);
         check("arst.rs1_busy", 32'(rs1_busy), 32'd0);
         check("arst.rs2_data", rs2_data, 32'h0);
         check("arst.pend", 32'(pend_cnt), 32'd0);
         check("arst.ready", 32'(rsv_ready), 32'd0);
      end
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5, "post_rst");
      check("post_rst.x3", last_rs1_data, 32'h0);

      for (int n = 0; n < 400; n++) begin
         we = ($urandom_range(0, 2) != 0);
         wa = 5'($urandom_range(0, NREG - 1));
         wd = $urandom;
         rv = ($urandom_range(0, 3) != 0);
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NREG - 1));
         r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, NREG - 1));
         r2 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, NREG - 1));
         step(we, wa, wd, rv, ra, r1, r2, "rand");
      end

      for (int a = 0; a < NREG; a++) begin
         step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(NREG - 1 - a), "sweep");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
